snake_move_ctrl: RTL and testbench



---
 rtl/snake_pkg.sv | 22 ++
 rtl/snake_move_ctrl_tick.sv | 29 ++
 rtl/snake_move_ctrl.sv | 160 ++++++++++++++++
 tb/tb_snake_move_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake motion controller: direction codes,
// controller states and the reversal test applied to direction requests.
package snake_pkg;

   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_DOWN  = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_RIGHT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_MOVE,
      ST_DEAD
   } state_t;

   // Opposite directions share the axis bit and differ in the sense bit.
   function automatic logic is_opposite(input logic [1:0] a, input logic [1:0] b);
      return (a[1] == b[1]) && (a[0] != b[0]);
   endfunction

endpackage

// File: rtl/snake_move_ctrl_tick.sv
// Move-step pacing counter: counts 0..TICK_DIV-1 while enabled and flags
// the terminal count; clear has priority over counting.
module snake_tick #(
   parameter int unsigned TICK_DIV = 5000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic wrap
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] cnt;

   assign wrap = en && (cnt == CW'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= wrap ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/snake_move_ctrl.sv
// Snake motion sequencer: paces moves, shifts the body, grows on food,
// detects wall/self collisions and answers renderer occupancy queries.
module snake_move_ctrl
   import snake_pkg::*;
#(
   parameter int GRID_W   = 32,
   parameter int GRID_H   = 24,
   parameter int COORD_W  = 5,
   parameter int MAX_LEN  = 16,
   parameter int INIT_LEN = 3,
   parameter int TICK_DIV = 5000000
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [1:0]                   dir_in,
   input  logic [COORD_W-1:0]           food_x,
   input  logic [COORD_W-1:0]           food_y,
   input  logic [COORD_W-1:0]           query_x,
   input  logic [COORD_W-1:0]           query_y,
   output logic                         query_hit,
   output logic [COORD_W-1:0]           head_x,
   output logic [COORD_W-1:0]           head_y,
   output logic [$clog2(MAX_LEN+1)-1:0] length,
   output logic                         step,
   output logic                         ate,
   output logic                         game_over
);

   localparam int LEN_W = $clog2(MAX_LEN + 1);

   state_t             state;
   logic [1:0]         cur_dir;
   logic [1:0]         pend_dir;
   logic [COORD_W-1:0] seg_x [MAX_LEN];
   logic [COORD_W-1:0] seg_y [MAX_LEN];
   logic [LEN_W-1:0]   len_q;

   logic               tick_en;
   logic               tick_clr;
   logic               tick_wrap;

   logic [COORD_W-1:0] nxt_x;
   logic [COORD_W-1:0] nxt_y;
   logic               wall;
   logic               grow;
   logic               self_hit;
   logic [LEN_W-1:0]   lim;
   logic               qhit;

   function automatic logic [COORD_W-1:0] init_x(input int unsigned i);
      return (i < INIT_LEN) ? COORD_W'(GRID_W / 2 - i) : '0;
   endfunction

   assign head_x = seg_x[0];
   assign head_y = seg_y[0];
   assign length = len_q;

   assign tick_en  = (state == ST_RUN) || (state == ST_MOVE);
   assign tick_clr = start && ((state == ST_IDLE) || (state == ST_DEAD));

   snake_tick #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (tick_en),
      .clr   (tick_clr),
      .wrap  (tick_wrap)
   );

   always_comb begin
      nxt_x = seg_x[0];
      nxt_y = seg_y[0];
      wall  = 1'b0;
      case (pend_dir)
         DIR_UP:    if (seg_y[0] == '0) wall = 1'b1; else nxt_y = seg_y[0] - COORD_W'(1);
         DIR_DOWN:  if (seg_y[0] == COORD_W'(GRID_H - 1)) wall = 1'b1; else nxt_y = seg_y[0] + COORD_W'(1);
         DIR_LEFT:  if (seg_x[0] == '0) wall = 1'b1; else nxt_x = seg_x[0] - COORD_W'(1);
         default:   if (seg_x[0] == COORD_W'(GRID_W - 1)) wall = 1'b1; else nxt_x = seg_x[0] + COORD_W'(1);
      endcase
      grow = (nxt_x == food_x) && (nxt_y == food_y);
      // The tail cell vacates this move unless the snake grows.
      lim = grow ? len_q : len_q - LEN_W'(1);
      self_hit = 1'b0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
         if ((LEN_W'(i) < lim) && (seg_x[i] == nxt_x) && (seg_y[i] == nxt_y)) self_hit = 1'b1;
      end
   end

   always_comb begin
      qhit = 1'b0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
         if ((LEN_W'(i) < len_q) && (seg_x[i] == query_x) && (seg_y[i] == query_y)) qhit = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cur_dir   <= DIR_RIGHT;
         pend_dir  <= DIR_RIGHT;
         len_q     <= LEN_W'(INIT_LEN);
         step      <= 1'b0;
         ate       <= 1'b0;
         game_over <= 1'b0;
         query_hit <= 1'b0;
         for (int unsigned i = 0; i < MAX_LEN; i++) begin
            seg_x[i] <= init_x(i);
            seg_y[i] <= COORD_W'(GRID_H / 2);
         end
      end else begin
         step      <= 1'b0;
         ate       <= 1'b0;
         query_hit <= qhit;
         case (state)
            ST_IDLE: begin
               if (start) state <= ST_RUN;
            end
            ST_RUN: begin
               if (!is_opposite(dir_in, cur_dir)) pend_dir <= dir_in;
               if (tick_wrap) state <= ST_MOVE;
            end
            ST_MOVE: begin
               cur_dir <= pend_dir;
               if (wall || self_hit) begin
                  state     <= ST_DEAD;
                  game_over <= 1'b1;
               end else begin
                  for (int unsigned i = 1; i < MAX_LEN; i++) begin
                     seg_x[i] <= seg_x[i-1];
                     seg_y[i] <= seg_y[i-1];
                  end
                  seg_x[0] <= nxt_x;
                  seg_y[0] <= nxt_y;
                  step     <= 1'b1;
                  state    <= ST_RUN;
                  if (grow) begin
                     ate <= 1'b1;
                     if (len_q < LEN_W'(MAX_LEN)) len_q <= len_q + LEN_W'(1);
                  end
               end
            end
            ST_DEAD: begin
               if (start) begin
                  state     <= ST_RUN;
                  cur_dir   <= DIR_RIGHT;
                  pend_dir  <= DIR_RIGHT;
                  len_q     <= LEN_W'(INIT_LEN);
                  game_over <= 1'b0;
                  for (int unsigned i = 0; i < MAX_LEN; i++) begin
                     seg_x[i] <= init_x(i);
                     seg_y[i] <= COORD_W'(GRID_H / 2);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Self-checking bench for snake_move_ctrl with TICK_DIV=4: expected moves are
// queued as stimulus is driven and compared whenever the DUT pulses step.
module tb_snake_move_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [1:0] dir_in = 2'b11;
   logic [4:0] food_x = '0;
   logic [4:0] food_y = '0;
   logic [4:0] query_x = '0;
   logic [4:0] query_y = '0;
   logic       query_hit;
   logic [4:0] head_x;
   logic [4:0] head_y;
   logic [4:0] length;
   logic       step;
   logic       ate;
   logic       game_over;

   typedef struct {
      int x;
      int y;
      int len;
      int ate;
      bit chk_period;
   } step_exp_t;

   typedef struct {
      logic [4:0] qx;
      logic [4:0] qy;
      int         hit;
   } qvec_t;

   step_exp_t exp_q[$];
   qvec_t     qtab[$];
   int        checks = 0;
   int        errors = 0;
   int        cyc = 0;
   int        last_step_cyc = 0;

   snake_move_ctrl #(.TICK_DIV(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .dir_in    (dir_in),
      .food_x    (food_x),
      .food_y    (food_y),
      .query_x   (query_x),
      .query_y   (query_y),
      .query_hit (query_hit),
      .head_x    (head_x),
      .head_y    (head_y),
      .length    (length),
      .step      (step),
      .ate       (ate),
      .game_over (game_over)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic push(input int x, input int y, input int len, input int a, input bit cp);
      step_exp_t e;
      e.x = x; e.y = y; e.len = len; e.ate = a; e.chk_period = cp;
      exp_q.push_back(e);
   endtask

   task automatic qadd(input int x, input int y, input int hit);
      qvec_t v;
      v.qx = 5'(x); v.qy = 5'(y); v.hit = hit;
      qtab.push_back(v);
   endtask

   task automatic run_qtab(input string name);
      foreach (qtab[i]) begin
         query_x = qtab[i].qx;
         query_y = qtab[i].qy;
         @(negedge clk);
         @(negedge clk);
         check($sformatf("%s_q(%0d,%0d)", name, qtab[i].qx, qtab[i].qy), query_hit, qtab[i].hit);
      end
      qtab.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0;
      dir_in = 2'b11;
      food_x = '0; food_y = '0;
      query_x = '0; query_y = '0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_q(input int target, input int budget, input string name);
      int n = 0;
      while (exp_q.size() > target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({name, "_steps_seen"}, (exp_q.size() > target) ? 0 : 1, 1);
   endtask

   task automatic wait_dead(input int budget);
      int n = 0;
      while (!game_over && n < budget) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      fork
         forever begin
            step_exp_t e;
            @(negedge clk);
            cyc++;
            if (rst_n && step) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_step: got step to (%0d,%0d) expected none", head_x, head_y);
               end else begin
                  e = exp_q.pop_front();
                  check("step_head_x", head_x, e.x);
                  check("step_head_y", head_y, e.y);
                  check("step_length", length, e.len);
                  check("step_ate", ate, e.ate);
                  check("step_game_over", game_over, 0);
                  if (e.chk_period) check("step_period", cyc - last_step_cyc, 4);
               end
               last_step_cyc = cyc;
            end
         end
      join_none

      // reset state and occupancy lookups
      do_reset();
      check("rst_head_x", head_x, 16);
      check("rst_head_y", head_y, 12);
      check("rst_length", length, 3);
      check("rst_step", step, 0);
      check("rst_ate", ate, 0);
      check("rst_game_over", game_over, 0);
      check("rst_query_hit", query_hit, 0);
      qadd(16, 12, 1); qadd(15, 12, 1); qadd(14, 12, 1); qadd(13, 12, 0);
      qadd(17, 12, 0); qadd(16, 11, 0); qadd(0, 0, 0);
      run_qtab("rst");

      // straight run to the right, period 4
      do_reset();
      push(17, 12, 3, 0, 0); push(18, 12, 3, 0, 1); push(19, 12, 3, 0, 1);
      pulse_start();
      wait_q(0, 40, "run_right");
      check("run_right_game_over", game_over, 0);
      check("run_right_length", length, 3);

      // reversal ignored; later illegal request does not override a legal one
      do_reset();
      push(17, 12, 3, 0, 0); push(18, 12, 3, 0, 1); push(18, 11, 3, 0, 1);
      pulse_start();
      wait_q(2, 20, "dir_a");
      dir_in = 2'b10;
      @(negedge clk);
      dir_in = 2'b11;
      wait_q(1, 20, "dir_b");
      dir_in = 2'b00;
      @(negedge clk);
      dir_in = 2'b10;
      wait_q(0, 20, "dir_c");

      // eat on first step, then run into the right wall
      do_reset();
      food_x = 5'd17; food_y = 5'd12;
      push(17, 12, 4, 1, 0);
      for (int x = 18; x <= 31; x++) push(x, 12, 4, 0, 1);
      pulse_start();
      wait_q(0, 100, "wall_run");
      wait_dead(12);
      check("wall_game_over", game_over, 1);
      check("wall_head_x", head_x, 31);
      check("wall_head_y", head_y, 12);
      check("wall_length", length, 4);
      repeat (8) @(negedge clk);
      check("wall_frozen_x", head_x, 31);
      check("wall_still_dead", game_over, 1);
      qadd(31, 12, 1); qadd(28, 12, 1); qadd(27, 12, 0); qadd(16, 12, 0);
      run_qtab("dead");
      food_x = '0; food_y = '0;
      push(17, 12, 3, 0, 0);
      pulse_start();
      check("restart_game_over", game_over, 0);
      check("restart_head_x", head_x, 16);
      check("restart_head_y", head_y, 12);
      check("restart_length", length, 3);
      wait_q(0, 20, "restart_run");

      // length 5: up, left, down bites the body
      do_reset();
      food_x = 5'd17; food_y = 5'd12;
      push(17, 12, 4, 1, 0); push(18, 12, 5, 1, 1); push(18, 11, 5, 0, 1); push(17, 11, 5, 0, 1);
      pulse_start();
      wait_q(3, 20, "self5_a");
      food_x = 5'd18;
      wait_q(2, 20, "self5_b");
      food_x = '0; food_y = '0;
      dir_in = 2'b00;
      wait_q(1, 20, "self5_c");
      dir_in = 2'b10;
      wait_q(0, 20, "self5_d");
      dir_in = 2'b01;
      wait_dead(12);
      check("self5_game_over", game_over, 1);
      check("self5_head_x", head_x, 17);
      check("self5_head_y", head_y, 11);
      check("self5_length", length, 5);

      // length 4: same loop enters the vacating tail cell legally
      do_reset();
      food_x = 5'd17; food_y = 5'd12;
      push(17, 12, 4, 1, 0); push(17, 11, 4, 0, 1); push(16, 11, 4, 0, 1); push(16, 12, 4, 0, 1);
      pulse_start();
      wait_q(3, 20, "tail4_a");
      food_x = '0; food_y = '0;
      dir_in = 2'b00;
      wait_q(2, 20, "tail4_b");
      dir_in = 2'b10;
      wait_q(1, 20, "tail4_c");
      dir_in = 2'b01;
      wait_q(0, 20, "tail4_d");
      check("tail4_game_over", game_over, 0);
      check("tail4_length", length, 4);
      do_reset();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
